// File: rtl/conv_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_row_scheduler
// Description : Line-buffer sequencer for the convolution front end. Generates
//               write addresses for the incoming pixel stream, counts resident
//               rows, and issues K-row sliding-window row reads to the engine.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_row_scheduler #(
    parameter int IMG_W      = 10,
    parameter int IMG_H      = 30,
    parameter int K          = 5,
    parameter int PIX_PER_WR = 2,
    parameter int AW         = $clog2(IMG_W * IMG_H),
    parameter int RW         = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    input  logic          conv_ready,
    output logic          rd_en,
    output logic [RW-1:0] rd_row,
    output logic          win_first,
    output logic          win_last,
    output logic [RW-1:0] out_row,
    output logic          busy,
    output logic          done
);

    // Write counter carries one extra bit so it can reach IMG_W*IMG_H even
    // when the frame size is an exact power of two.
    localparam int CNT_W = AW + 1;
    localparam int COL_W = $clog2(IMG_W) + 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;

    localparam logic [CNT_W-1:0] C_TOTAL_PIX = CNT_W'(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0] C_CNT_STEP  = CNT_W'(PIX_PER_WR);
    localparam logic [COL_W-1:0] C_COL_STEP  = COL_W'(PIX_PER_WR);
    localparam logic [COL_W-1:0] C_COL_LAST  = COL_W'(IMG_W - PIX_PER_WR);
    localparam logic [RW:0]      C_ROW_ONE   = (RW+1)'(1);
    localparam logic [RW:0]      C_K_ROWS    = (RW+1)'(K);
    localparam logic [KW-1:0]    C_K_LAST    = KW'(K - 1);
    localparam logic [KW-1:0]    C_K_ONE     = KW'(1);
    localparam logic [RW-1:0]    C_ROW_LAST  = RW'(IMG_H - K);
    localparam logic [RW-1:0]    C_OROW_ONE  = RW'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           state_q,        state_d;
    logic [CNT_W-1:0] wr_cnt_q,       wr_cnt_d;
    logic [COL_W-1:0] col_q,          col_d;
    logic [RW:0]      rows_done_q,    rows_done_d;
    logic [RW-1:0]    out_row_q,      out_row_d;
    logic [KW-1:0]    k_q,            k_d;
    logic             frame_issued_q, frame_issued_d;
    logic             done_q,         done_d;

    logic             w_active;
    logic             w_rows_avail;
    logic [RW:0]      w_rows_needed;

    // Handshake strobes and read address, combinational from state and inputs.
    always_comb begin
        w_active      = (state_q == ST_ACTIVE);
        w_rows_needed = {1'b0, out_row_q} + C_K_ROWS;
        // Only a window's first row waits for data; its later rows are older.
        w_rows_avail  = (k_q != '0) || (rows_done_q >= w_rows_needed);
        in_ready      = w_active && (wr_cnt_q < C_TOTAL_PIX);
        wr_en         = in_valid && in_ready;
        rd_en         = w_active && conv_ready && !frame_issued_q && w_rows_avail;
        win_first     = rd_en && (k_q == '0);
        win_last      = rd_en && (k_q == C_K_LAST);
    end

    assign wr_addr = wr_cnt_q[AW-1:0];
    assign rd_row  = out_row_q + RW'(k_q);
    assign out_row = out_row_q;
    assign busy    = (state_q == ST_ACTIVE);
    assign done    = done_q;

    // Next-state logic for the FSM, write-side and read-side counters.
    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        col_d          = col_q;
        rows_done_d    = rows_done_q;
        out_row_d      = out_row_q;
        k_d            = k_q;
        frame_issued_d = frame_issued_q;
        done_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_ACTIVE;
                    wr_cnt_d       = '0;
                    col_d          = '0;
                    rows_done_d    = '0;
                    out_row_d      = '0;
                    k_d            = '0;
                    frame_issued_d = 1'b0;
                end
            end
            default: begin
                if (wr_en) begin
                    wr_cnt_d = wr_cnt_q + C_CNT_STEP;
                    if (col_q == C_COL_LAST) begin
                        col_d       = '0;
                        rows_done_d = rows_done_q + C_ROW_ONE;
                    end else begin
                        col_d = col_q + C_COL_STEP;
                    end
                end
                if (rd_en) begin
                    if (k_q == C_K_LAST) begin
                        k_d = '0;
                        if (out_row_q == C_ROW_LAST) begin
                            // Final read of the frame: out_row stays on the last window.
                            frame_issued_d = 1'b1;
                            state_d        = ST_IDLE;
                            done_d         = 1'b1;
                        end else begin
                            out_row_d = out_row_q + C_OROW_ONE;
                        end
                    end else begin
                        k_d = k_q + C_K_ONE;
                    end
                end
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wr_cnt_q       <= '0;
            col_q          <= '0;
            rows_done_q    <= '0;
            out_row_q      <= '0;
            k_q            <= '0;
            frame_issued_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            col_q          <= col_d;
            rows_done_q    <= rows_done_d;
            out_row_q      <= out_row_d;
            k_q            <= k_d;
            frame_issued_q <= frame_issued_d;
            done_q         <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_row_scheduler
// Description : Randomized self-checking bench for conv_row_scheduler against
//               an index-arithmetic reference model of beats and window reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_row_scheduler;

    localparam int IMG_W         = 10;
    localparam int IMG_H         = 30;
    localparam int K             = 5;
    localparam int PIX_PER_WR    = 2;
    localparam int AW            = 9;
    localparam int RW            = 5;
    localparam int BEATS_PER_ROW = IMG_W / PIX_PER_WR;
    localparam int TOTAL_BEATS   = IMG_W * IMG_H / PIX_PER_WR;
    localparam int TOTAL_READS   = (IMG_H - K + 1) * K;
    localparam int CYCLE_LIMIT   = 3000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          conv_ready = 1'b0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [RW-1:0] rd_row;
    logic          win_first;
    logic          win_last;
    logic [RW-1:0] out_row;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    conv_row_scheduler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIX_PER_WR(PIX_PER_WR),
        .AW(AW), .RW(RW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .conv_ready(conv_ready), .rd_en(rd_en), .rd_row(rd_row),
        .win_first(win_first), .win_last(win_last), .out_row(out_row),
        .busy(busy), .done(done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: frame progress as beats accepted and reads issued.
    bit m_active = 1'b0;
    int m_beats  = 0;
    int m_idx    = 0;
    bit m_done   = 1'b0;

    int cyc, dones, first_rd, done_cyc, obs_reads, obs_beats;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, check at negedge, advance the model.
    task automatic run_cycle(input bit st, input bit iv, input bit cr);
        int  rows, o, kk;
        bit  e_ir, e_wr, e_rd;
        start      = st;
        in_valid   = iv;
        conv_ready = cr;
        @(negedge clk);
        rows = m_beats / BEATS_PER_ROW;
        o    = m_idx / K;
        kk   = m_idx % K;
        e_ir = m_active && (m_beats < TOTAL_BEATS);
        e_wr = e_ir && iv;
        e_rd = m_active && cr && (m_idx < TOTAL_READS) && ((kk != 0) || (rows >= o + K));
        chk_eq("busy",      busy,      m_active);
        chk_eq("in_ready",  in_ready,  e_ir);
        chk_eq("wr_en",     wr_en,     e_wr);
        chk_eq("wr_addr",   wr_addr,   (m_beats * PIX_PER_WR) % (1 << AW));
        chk_eq("rd_en",     rd_en,     e_rd);
        chk_eq("win_first", win_first, e_rd && (kk == 0));
        chk_eq("win_last",  win_last,  e_rd && (kk == K - 1));
        chk_eq("done",      done,      m_done);
        if (e_rd) chk_eq("rd_row", rd_row, o + kk);
        if (m_active && m_idx < TOTAL_READS) chk_eq("out_row", out_row, o);
        if (rd_en === 1'b1) begin
            obs_reads++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (wr_en === 1'b1) obs_beats++;
        if (done === 1'b1) begin
            dones++;
            done_cyc = cyc;
        end
        m_done = 1'b0;
        if (m_active) begin
            if (e_wr) m_beats++;
            if (e_rd) begin
                m_idx++;
                if (m_idx == TOTAL_READS) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end else if (st && rst_n) begin
            m_active = 1'b1;
            m_beats  = 0;
            m_idx    = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset assertion between clock edges, then release.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_in_ready",  in_ready,  0);
        chk_eq("rst_wr_en",     wr_en,     0);
        chk_eq("rst_wr_addr",   wr_addr,   0);
        chk_eq("rst_rd_en",     rd_en,     0);
        chk_eq("rst_rd_row",    rd_row,    0);
        chk_eq("rst_win_first", win_first, 0);
        chk_eq("rst_win_last",  win_last,  0);
        chk_eq("rst_out_row",   out_row,   0);
        chk_eq("rst_busy",      busy,      0);
        chk_eq("rst_done",      done,      0);
        m_active = 1'b0;
        m_beats  = 0;
        m_idx    = 0;
        m_done   = 1'b0;
        repeat (2) run_cycle(1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
    endtask

    // mode 0: full rate; 1: source every 3rd cycle; 2: random; 3: mid-window stall + extra start
    task automatic run_frame(input int mode, input int abort_at);
        bit st, iv, cr;
        cyc       = 0;
        dones     = 0;
        first_rd  = -1;
        done_cyc  = -1;
        obs_reads = 0;
        obs_beats = 0;
        run_cycle(1'b1, 1'b1, 1'b1);
        while (dones == 0 && cyc < CYCLE_LIMIT) begin
            if (abort_at > 0 && cyc == abort_at) begin
                do_reset();
                chk_eq("no_done_on_abort", dones, 0);
                return;
            end
            case (mode)
                0: begin st = 1'b0; iv = 1'b1; cr = 1'b1; end
                1: begin st = 1'b0; iv = (cyc % 3 == 0); cr = 1'b1; end
                3: begin st = (cyc == 40); iv = 1'b1; cr = !(cyc >= 44 && cyc <= 50); end
                default: begin
                    iv = ($urandom_range(0, 3) != 0);
                    cr = ($urandom_range(0, 2) != 0);
                    st = (m_active && m_idx < TOTAL_READS / 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
                end
            endcase
            run_cycle(st, iv, cr);
        end
        chk_eq("frame_done_seen", dones, 1);
        chk_eq("frame_reads", obs_reads, TOTAL_READS);
        chk_eq("frame_beats", obs_beats, TOTAL_BEATS);
        if (mode == 0) begin
            chk_eq("first_rd_cycle", first_rd, 26);
            chk_eq("done_cycle", done_cyc, 156);
        end
        repeat (3) run_cycle(1'b0, 1'b1, 1'b1);
        chk_eq("single_done", dones, 1);
    endtask

    initial begin
        cyc   = 0;
        dones = 0;
        #2;
        chk_eq("init_busy",    busy,    0);
        chk_eq("init_wr_addr", wr_addr, 0);
        chk_eq("init_rd_row",  rd_row,  0);
        run_cycle(1'b1, 1'b1, 1'b1);
        run_cycle(1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(3, 0);
        run_frame(2, 60);
        run_frame(0, 0);
        repeat (3) run_frame(2, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
